// File: rtl/decode_pkg.sv
// Shared types for the decode queue: opcode encodings and the decoded control bundle.
package decode_pkg;

  typedef enum logic [6:0] {
    OP_R      = 7'b0110011,
    OP_IALU   = 7'b0010011,
    OP_LOAD   = 7'b0000011,
    OP_STORE  = 7'b0100011,
    OP_BRANCH = 7'b1100011,
    OP_JAL    = 7'b1101111,
    OP_JALR   = 7'b1100111,
    OP_LUI    = 7'b0110111,
    OP_AUIPC  = 7'b0010111,
    OP_SYSTEM = 7'b1110011,
    OP_AMO    = 7'b0101111,
    OP_BUBBLE = 7'b0000000
  } opcode_e;

  // Field order fixes the packed layout: reg_write is the MSB, illegal_inst the LSB.
  typedef struct packed {
    logic       reg_write;
    logic       mem_write;
    logic       mem_to_reg;
    logic       branch;
    logic       alu_src;
    logic       jump;
    logic [1:0] alu_op;
    logic       lui;
    logic       auipc;
    logic       jal;
    logic       r_type;
    logic       sys_inst;
    logic       is_atomic;
    logic       illegal_inst;
  } ctrl_t;

  localparam int CTRL_W = $bits(ctrl_t);

endpackage

// File: rtl/opcode_decoder.sv
// Combinational opcode -> ctrl_t decode. Build with ATOMIC_EXT_EN defined to
// accept AMO opcodes; otherwise they decode as illegal.
module opcode_decoder
  import decode_pkg::*;
(
  input  logic [6:0] i_opcode,
  output ctrl_t      o_ctrl
);

  always_comb begin
    o_ctrl = '0;
    case (i_opcode)
      OP_R: begin
        o_ctrl.reg_write = 1'b1;
        o_ctrl.r_type    = 1'b1;
        o_ctrl.alu_op    = 2'b11;
      end
      OP_IALU: begin
        o_ctrl.reg_write = 1'b1;
        o_ctrl.alu_src   = 1'b1;
        o_ctrl.alu_op    = 2'b01;
      end
      OP_LOAD: begin
        o_ctrl.reg_write  = 1'b1;
        o_ctrl.mem_to_reg = 1'b1;
        o_ctrl.alu_src    = 1'b1;
      end
      OP_STORE: begin
        o_ctrl.mem_write = 1'b1;
        o_ctrl.alu_src   = 1'b1;
      end
      OP_BRANCH: begin
        o_ctrl.branch = 1'b1;
        o_ctrl.alu_op = 2'b10;
      end
      OP_JAL: begin
        o_ctrl.jump      = 1'b1;
        o_ctrl.jal       = 1'b1;
        o_ctrl.reg_write = 1'b1;
      end
      OP_JALR: begin
        o_ctrl.jump      = 1'b1;
        o_ctrl.reg_write = 1'b1;
      end
      OP_LUI: begin
        o_ctrl.lui       = 1'b1;
        o_ctrl.alu_src   = 1'b1;
        o_ctrl.reg_write = 1'b1;
      end
      OP_AUIPC: begin
        o_ctrl.auipc     = 1'b1;
        o_ctrl.alu_src   = 1'b1;
        o_ctrl.reg_write = 1'b1;
      end
      OP_SYSTEM: begin
        o_ctrl.sys_inst  = 1'b1;
        o_ctrl.reg_write = 1'b1;
      end
`ifdef ATOMIC_EXT_EN
      OP_AMO: begin
        o_ctrl.is_atomic = 1'b1;
        o_ctrl.reg_write = 1'b1;
      end
`endif
      // Bubbles never reach the FIFO, so their bundle is irrelevant.
      OP_BUBBLE: o_ctrl = '0;
      default:   o_ctrl.illegal_inst = 1'b1;
    endcase
  end

endmodule

// File: rtl/decode_queue.sv
// Decode-and-buffer stage: decodes fetched opcodes on entry and holds them in a
// DEPTH-entry FIFO with flush support. AMO decode depends on ATOMIC_EXT_EN.
module decode_queue
  import decode_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int XLEN  = 32,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_inst,
  input  logic [XLEN-1:0]  in_pc,
  output logic             out_valid,
  input  logic             out_ready,
  output ctrl_t            out_ctrl,
  output logic [31:0]      out_inst,
  output logic [XLEN-1:0]  out_pc,
  output logic [CNT_W-1:0] illegal_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] CNT_FULL = (AW+1)'(DEPTH);

  ctrl_t           r_ctrl_mem [DEPTH];
  logic [31:0]     r_inst_mem [DEPTH];
  logic [XLEN-1:0] r_pc_mem   [DEPTH];

  logic [AW-1:0]   r_wptr;
  logic [AW-1:0]   r_rptr;
  logic [AW:0]     r_cnt;
  logic [CNT_W-1:0] r_ill_cnt;

  ctrl_t w_dec;
  logic  w_push;
  logic  w_pop;

  opcode_decoder u_dec (
    .i_opcode (in_inst[6:0]),
    .o_ctrl   (w_dec)
  );

  assign in_ready  = (r_cnt < CNT_FULL);
  assign out_valid = (r_cnt != '0);
  assign w_push    = in_valid & in_ready & ~flush & (in_inst[6:0] != OP_BUBBLE);
  assign w_pop     = out_valid & out_ready & ~flush;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_cnt  <= '0;
    end else if (flush) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_cnt  <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + AW'(1);
      if (w_pop)  r_rptr <= r_rptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_cnt <= r_cnt + (AW+1)'(1);
        2'b01:   r_cnt <= r_cnt - (AW+1)'(1);
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  // Storage needs no reset: only entries below r_cnt are ever exposed.
  always_ff @(posedge clk) begin
    if (!reset && w_push) begin
      r_ctrl_mem[r_wptr] <= w_dec;
      r_inst_mem[r_wptr] <= in_inst;
      r_pc_mem[r_wptr]   <= in_pc;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_ill_cnt <= '0;
    end else if (w_push && w_dec.illegal_inst && (r_ill_cnt != '1)) begin
      r_ill_cnt <= r_ill_cnt + CNT_W'(1);
    end
  end

  assign illegal_cnt = r_ill_cnt;
  assign out_ctrl    = out_valid ? r_ctrl_mem[r_rptr] : '0;
  assign out_inst    = out_valid ? r_inst_mem[r_rptr] : '0;
  assign out_pc      = out_valid ? r_pc_mem[r_rptr]   : '0;

endmodule

// File: tb/tb_decode_queue.sv
// Self-checking bench for decode_queue: vector table plus a scoreboard of
// expected head entries, checked every cycle against an independent model.
module tb_decode_queue;
  import decode_pkg::*;

  localparam int DEPTH = 4;
  localparam int XLEN  = 32;
  localparam int CNT_W = 8;

  logic             clk = 1'b0;
  logic             reset;
  logic             flush;
  logic             in_valid;
  logic             in_ready;
  logic [31:0]      in_inst;
  logic [XLEN-1:0]  in_pc;
  logic             out_valid;
  logic             out_ready;
  ctrl_t            out_ctrl;
  logic [31:0]      out_inst;
  logic [XLEN-1:0]  out_pc;
  logic [CNT_W-1:0] illegal_cnt;

  decode_queue #(.DEPTH(DEPTH), .XLEN(XLEN), .CNT_W(CNT_W)) dut (
    .clk         (clk),
    .reset       (reset),
    .flush       (flush),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_inst     (in_inst),
    .in_pc       (in_pc),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_ctrl    (out_ctrl),
    .out_inst    (out_inst),
    .out_pc      (out_pc),
    .illegal_cnt (illegal_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] inst;
    logic [31:0] pc;
    logic [14:0] ctrl;
  } vec_t;

  localparam int NVEC = 13;
  vec_t tbl [NVEC];
  vec_t sb [$];
  vec_t pend;
  int   m_cnt;
  int   m_ill;
  int   checks;
  int   failures;

  // Bit order: reg_write mem_write mem_to_reg branch alu_src jump alu_op[1:0]
  //            lui auipc jal r_type sys_inst is_atomic illegal_inst
  function automatic logic [14:0] c(input logic rw, mw, mr, br, as, j,
                                    input logic [1:0] aop,
                                    input logic lu, au, jl, rt, sy, at, il);
    return {rw, mw, mr, br, as, j, aop, lu, au, jl, rt, sy, at, il};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input vec_t v);
    in_valid = 1'b1;
    in_inst  = v.inst;
    in_pc    = v.pc;
    pend     = v;
  endtask

  task automatic idle();
    in_valid = 1'b0;
    in_inst  = 32'h0;
    in_pc    = 32'h0;
  endtask

  // Check the current outputs against the model, advance the model by the
  // handshakes that will happen on the coming edge, then cross that edge.
  task automatic step();
    logic push, pop;
    if (reset) begin
      sb.delete();
      m_cnt = 0;
      m_ill = 0;
    end else begin
      chk("in_ready", 32'(in_ready), 32'(m_cnt < DEPTH));
      chk("out_valid", 32'(out_valid), 32'(m_cnt != 0));
      if (m_cnt != 0) begin
        chk("head_ctrl", 32'(out_ctrl), 32'(sb[0].ctrl));
        chk("head_inst", out_inst, sb[0].inst);
        chk("head_pc", out_pc, sb[0].pc);
      end else begin
        chk("idle_zero", 32'(out_ctrl) | out_inst | out_pc, 32'h0);
      end
      chk("illegal_cnt", 32'(illegal_cnt), 32'(m_ill));
      push = in_valid && (m_cnt < DEPTH) && !flush && (in_inst[6:0] != 7'b0);
      pop  = (m_cnt != 0) && out_ready && !flush;
      if (flush) begin
        sb.delete();
      end else begin
        if (pop) void'(sb.pop_front());
        if (push) begin
          sb.push_back(pend);
          if (pend.ctrl[0] && m_ill != 255) m_ill++;
        end
      end
      m_cnt = sb.size();
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks = 0;
    failures = 0;
    m_cnt = 0;
    m_ill = 0;
    tbl[0]  = '{32'h00B50533, 32'h100, c(1,0,0,0,0,0,2'b11,0,0,0,1,0,0,0)};
    tbl[1]  = '{32'h00150513, 32'h104, c(1,0,0,0,1,0,2'b01,0,0,0,0,0,0,0)};
    tbl[2]  = '{32'h00052503, 32'h108, c(1,0,1,0,1,0,2'b00,0,0,0,0,0,0,0)};
    tbl[3]  = '{32'h00A52023, 32'h10C, c(0,1,0,0,1,0,2'b00,0,0,0,0,0,0,0)};
    tbl[4]  = '{32'h00B50463, 32'h110, c(0,0,0,1,0,0,2'b10,0,0,0,0,0,0,0)};
    tbl[5]  = '{32'h008000EF, 32'h114, c(1,0,0,0,0,1,2'b00,0,0,1,0,0,0,0)};
    tbl[6]  = '{32'h000500E7, 32'h118, c(1,0,0,0,0,1,2'b00,0,0,0,0,0,0,0)};
    tbl[7]  = '{32'h12345537, 32'h11C, c(1,0,0,0,1,0,2'b00,1,0,0,0,0,0,0)};
    tbl[8]  = '{32'h00001517, 32'h120, c(1,0,0,0,1,0,2'b00,0,1,0,0,0,0,0)};
    tbl[9]  = '{32'h00000073, 32'h124, c(1,0,0,0,0,0,2'b00,0,0,0,0,1,0,0)};
`ifdef ATOMIC_EXT_EN
    tbl[10] = '{32'h0805262F, 32'h128, c(1,0,0,0,0,0,2'b00,0,0,0,0,0,1,0)};
`else
    tbl[10] = '{32'h0805262F, 32'h128, c(0,0,0,0,0,0,2'b00,0,0,0,0,0,0,1)};
`endif
    tbl[11] = '{32'h0000007F, 32'h12C, c(0,0,0,0,0,0,2'b00,0,0,0,0,0,0,1)};
    tbl[12] = '{32'h00000000, 32'h130, 15'h0};

    // Reset with a live offer on the input that must be ignored.
    reset = 1'b1; flush = 1'b0; out_ready = 1'b1;
    drive(tbl[0]);
    @(posedge clk); #1;
    step(); step();
    reset = 1'b0;
    idle();
    step();

    // Back-to-back decode of every table entry with the consumer always ready.
    for (int i = 0; i < NVEC; i++) begin
      drive(tbl[i]);
      step();
    end
    idle();
    step(); step();

    // Fill to DEPTH with the consumer stalled; the fifth offer is refused.
    out_ready = 1'b0;
    for (int i = 0; i < DEPTH + 1; i++) begin
      drive(tbl[i + 1]);
      if (i == DEPTH) chk("full_ready", 32'(in_ready), 32'h0);
      step();
    end
    idle();
    step();
    out_ready = 1'b1;
    for (int i = 0; i < DEPTH + 1; i++) step();

    // A lone bubble leaves the queue empty.
    drive(tbl[12]);
    step();
    idle();
    step();
    chk("bubble_empty", 32'(out_valid), 32'h0);

    // Illegal counter saturation.
    for (int i = 0; i < 300; i++) begin
      drive('{32'h0000007F | (32'(i) << 7), 32'(i) << 2, tbl[11].ctrl});
      step();
    end
    idle();
    step(); step();
    chk("illegal_sat", 32'(illegal_cnt), 32'd255);

    // Flush with three held entries and a concurrent offer.
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive(tbl[i + 4]);
      step();
    end
    drive(tbl[0]);
    flush = 1'b1;
    step();
    flush = 1'b0;
    idle();
    step();
    chk("flush_empty", 32'(out_valid), 32'h0);
    chk("flush_ready", 32'(in_ready), 32'h1);

    // Queue still works after flush, and illegal_cnt survived it.
    out_ready = 1'b1;
    drive(tbl[3]);
    step();
    idle();
    step(); step();
    chk("ill_after_flush", 32'(illegal_cnt), 32'd255);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
